// File: rtl/pakout_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pakout_arbiter
//  Description : Four-source round-robin arbiter for the four-phase req/ack
//                packet channel. Latches the granted source's packet, replays
//                it on the output channel, then closes the source handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module pakout_arbiter #(
    parameter int ASZ = 4,
    parameter int DSZ = 8,
    parameter int RSZ = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,

    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,

    input  logic [ASZ-1:0] i1_src,
    input  logic [ASZ-1:0] i1_dst,
    input  logic [DSZ-1:0] i1_dat,
    input  logic [RSZ-1:0] i1_red,
    input  logic           i1_req,
    output logic           i1_ack,

    input  logic [ASZ-1:0] i2_src,
    input  logic [ASZ-1:0] i2_dst,
    input  logic [DSZ-1:0] i2_dat,
    input  logic [RSZ-1:0] i2_red,
    input  logic           i2_req,
    output logic           i2_ack,

    input  logic [ASZ-1:0] i3_src,
    input  logic [ASZ-1:0] i3_dst,
    input  logic [DSZ-1:0] i3_dat,
    input  logic [RSZ-1:0] i3_red,
    input  logic           i3_req,
    output logic           i3_ack,

    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,

    output logic           dbg_busy,
    output logic [1:0]     dbg_grant,
    output logic [7:0]     dbg_pkt_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_OUT_REL = 2'd2,
        S_IN_ACK  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      grant_q, grant_d;
    logic [ASZ-1:0]  src_q, src_d;
    logic [ASZ-1:0]  dst_q, dst_d;
    logic [DSZ-1:0]  dat_q, dat_d;
    logic [RSZ-1:0]  red_q, red_d;
    logic            req_q, req_d;
    logic [3:0]      ack_q, ack_d;
    logic [7:0]      cnt_q, cnt_d;

    // Source inputs gathered into indexable form for the round-robin scan
    logic [3:0]      w_req;
    logic [ASZ-1:0]  w_src [4];
    logic [ASZ-1:0]  w_dst [4];
    logic [DSZ-1:0]  w_dat [4];
    logic [RSZ-1:0]  w_red [4];

    assign w_req = {i3_req, i2_req, i1_req, i0_req};
    assign w_src = '{i0_src, i1_src, i2_src, i3_src};
    assign w_dst = '{i0_dst, i1_dst, i2_dst, i3_dst};
    assign w_dat = '{i0_dat, i1_dat, i2_dat, i3_dat};
    assign w_red = '{i0_red, i1_red, i2_red, i3_red};

    logic            w_found;
    logic [1:0]      w_idx;

    // Next-state logic: grant scan, output handshake, then source handshake
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        src_d    = src_q;
        dst_d    = dst_q;
        dat_d    = dat_q;
        red_d    = red_q;
        req_d    = req_q;
        ack_d    = ack_q;
        cnt_d    = cnt_q;
        w_found  = 1'b0;
        w_idx    = 2'd0;

        case (state_q)
            S_IDLE: begin
                // First requester at or after rr_ptr (mod 4) wins
                for (int j = 0; j < 4; j++) begin
                    w_idx = rr_ptr_q + 2'(j);
                    if (!w_found && w_req[w_idx]) begin
                        w_found = 1'b1;
                        grant_d = w_idx;
                        src_d   = w_src[w_idx];
                        dst_d   = w_dst[w_idx];
                        dat_d   = w_dat[w_idx];
                        red_d   = w_red[w_idx];
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                // A stale sink ack (e.g. left over across reset) blocks the request
                if (!req_q && !o0_ack) begin
                    req_d = 1'b1;
                end else if (req_q && o0_ack) begin
                    req_d   = 1'b0;
                    state_d = S_OUT_REL;
                end
            end
            S_OUT_REL: begin
                if (!o0_ack) begin
                    ack_d   = 4'b0001 << grant_q;
                    state_d = S_IN_ACK;
                end
            end
            S_IN_ACK: begin
                if (!w_req[grant_q]) begin
                    ack_d    = 4'b0000;
                    rr_ptr_d = grant_q + 2'd1;
                    cnt_d    = cnt_q + 8'd1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset discarding any transfer in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 2'd0;
            grant_q  <= 2'd0;
            src_q    <= '0;
            dst_q    <= '0;
            dat_q    <= '0;
            red_q    <= '0;
            req_q    <= 1'b0;
            ack_q    <= 4'b0000;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            dat_q    <= dat_d;
            red_q    <= red_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o0_src      = src_q;
    assign o0_dst      = dst_q;
    assign o0_dat      = dat_q;
    assign o0_red      = red_q;
    assign o0_req      = req_q;
    assign i0_ack      = ack_q[0];
    assign i1_ack      = ack_q[1];
    assign i2_ack      = ack_q[2];
    assign i3_ack      = ack_q[3];
    assign dbg_busy    = (state_q != S_IDLE);
    assign dbg_grant   = grant_q;
    assign dbg_pkt_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pakout_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pakout_arbiter
//  Description : Self-checking bench for pakout_arbiter: vector table,
//                hand-written corner sequences and randomized traffic against
//                a per-source queue / round-robin reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pakout_arbiter;

    localparam int ASZ = 4;
    localparam int DSZ = 8;
    localparam int RSZ = 4;
    localparam int PW  = 2 * ASZ + DSZ + RSZ;

    typedef logic [PW-1:0] pkt_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [ASZ-1:0] src [4];
    logic [ASZ-1:0] dst [4];
    logic [DSZ-1:0] dat [4];
    logic [RSZ-1:0] red [4];
    logic [3:0]     req;
    logic [3:0]     ack;
    logic [ASZ-1:0] o0_src, o0_dst;
    logic [DSZ-1:0] o0_dat;
    logic [RSZ-1:0] o0_red;
    logic           o0_req;
    logic           o0_ack;
    logic           dbg_busy;
    logic [1:0]     dbg_grant;
    logic [7:0]     dbg_pkt_cnt;

    always #5 clk = ~clk;

    pakout_arbiter #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
        .i_clk(clk), .i_rst(rst),
        .i0_src(src[0]), .i0_dst(dst[0]), .i0_dat(dat[0]), .i0_red(red[0]), .i0_req(req[0]), .i0_ack(ack[0]),
        .i1_src(src[1]), .i1_dst(dst[1]), .i1_dat(dat[1]), .i1_red(red[1]), .i1_req(req[1]), .i1_ack(ack[1]),
        .i2_src(src[2]), .i2_dst(dst[2]), .i2_dat(dat[2]), .i2_red(red[2]), .i2_req(req[2]), .i2_ack(ack[2]),
        .i3_src(src[3]), .i3_dst(dst[3]), .i3_dat(dat[3]), .i3_red(red[3]), .i3_req(req[3]), .i3_ack(ack[3]),
        .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_red(o0_red),
        .o0_req(o0_req), .o0_ack(o0_ack),
        .dbg_busy(dbg_busy), .dbg_grant(dbg_grant), .dbg_pkt_cnt(dbg_pkt_cnt)
    );

    // ---------------- bookkeeping and reference model ----------------
    int   total = 0;
    int   bad   = 0;
    pkt_t srcq [4][$];     // packets each source still has to deliver
    int   order_log [$];   // source order as seen by the sink
    int   mptr, mcnt, inflight;
    int   snk_dly;
    int   src_dly [4];
    int   rmax;
    bit   agents_on;
    bit   prev_req;
    pkt_t snap;

    typedef struct {
        logic [3:0] mask;
        int         n;
        logic [7:0] ord;   // expected grant order, 2 bits per slot, slot 0 in [1:0]
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rnd();
        return (rmax == 0) ? 0 : int'($urandom_range(rmax, 0));
    endfunction

    function automatic pkt_t out_pkt();
        return {o0_src, o0_dst, o0_dat, o0_red};
    endfunction

    task automatic set_src(input int k, input pkt_t p);
        {src[k], dst[k], dat[k], red[k]} = p;
    endtask

    // Sink and source agents; expected source picked by round-robin over
    // the sources that still hold packets.
    task automatic run_agents();
        int e;
        if (o0_req && !o0_ack) begin
            if (snk_dly > 0) snk_dly--;
            else begin
                e = -1;
                for (int j = 0; j < 4; j++)
                    if (e < 0 && srcq[(mptr + j) % 4].size() > 0) e = (mptr + j) % 4;
                if (e < 0) chk("unexpected_pkt", 1, 0);
                else begin
                    chk("pkt_fields", out_pkt(), srcq[e][0]);
                    chk("pkt_grant", dbg_grant, e);
                    mptr     = (e + 1) % 4;
                    inflight = e;
                    order_log.push_back(e);
                end
                o0_ack  = 1'b1;
                snk_dly = rnd();
            end
        end else if (!o0_req && o0_ack) begin
            if (snk_dly > 0) snk_dly--;
            else begin
                o0_ack  = 1'b0;
                snk_dly = rnd();
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (req[k] && ack[k]) begin
                if (src_dly[k] > 0) src_dly[k]--;
                else begin
                    chk("ack_source", k, inflight);
                    if (srcq[k].size() > 0) void'(srcq[k].pop_front());
                    req[k] = 1'b0;
                    mcnt++;
                    src_dly[k] = rnd();
                end
            end else if (!req[k] && !ack[k] && srcq[k].size() > 0) begin
                set_src(k, srcq[k][0]);
                req[k] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("ack_onehot", 32'($countones(ack) <= 1), 1);
        if (o0_req && prev_req) chk("o0_stable", out_pkt(), snap);
        if (o0_req && !prev_req) snap = out_pkt();
        prev_req = o0_req;
        if (agents_on) run_agents();
    endtask

    task automatic model_clear();
        mptr = 0; mcnt = 0; inflight = -1; snk_dly = 0; prev_req = 0;
        for (int k = 0; k < 4; k++) begin
            src_dly[k] = 0;
            srcq[k].delete();
        end
        order_log.delete();
    endtask

    task automatic do_reset();
        agents_on = 0;
        rst = 1'b1; req = 4'b0; o0_ack = 1'b0;
        for (int k = 0; k < 4; k++) set_src(k, '0);
        @(negedge clk);
        chk("rst_o0_req", o0_req, 0);
        chk("rst_acks", ack, 0);
        chk("rst_fields", out_pkt(), 0);
        chk("rst_dbg", {dbg_busy, dbg_grant, dbg_pkt_cnt}, 0);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        int n = 0;
        agents_on = 1;
        while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() > 0 ||
                req != 0 || o0_req || o0_ack || dbg_busy) && n < 20000) begin
            step();
            n++;
        end
        if (n >= 20000) chk("drain_timeout", 0, 1);
        agents_on = 0;
    endtask

    initial begin
        rmax = 0;
        // ---------------- vector table: masks loaded from idle ----------------
        tbl[0] = '{4'b1111, 4, 8'b11_10_01_00};
        tbl[1] = '{4'b0001, 1, 8'b00_00_00_00};
        tbl[2] = '{4'b0101, 2, 8'b00_00_00_10};
        tbl[3] = '{4'b1000, 1, 8'b00_00_00_11};
        tbl[4] = '{4'b1010, 2, 8'b00_00_11_01};
        tbl[5] = '{4'b0110, 2, 8'b00_00_10_01};
        tbl[6] = '{4'b0011, 2, 8'b00_00_01_00};
        tbl[7] = '{4'b1001, 2, 8'b00_00_00_11};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            order_log.delete();
            for (int k = 0; k < 4; k++)
                if (tbl[i].mask[k])
                    srcq[k].push_back({4'(k), 4'(i), 8'(16 * i + k), 4'(i + k)});
            drain();
            chk("tbl_count", order_log.size(), tbl[i].n);
            for (int j = 0; j < tbl[i].n && j < order_log.size(); j++) begin
                logic [7:0] o;
                o = tbl[i].ord;
                chk("tbl_order", order_log[j], 32'(o[2*j +: 2]));
            end
        end
        chk("tbl_pkt_cnt", dbg_pkt_cnt, 16);

        // ---------------- single source i2, 1-cycle sink ----------------
        do_reset();
        set_src(2, {4'd3, 4'd1, 8'd5, 4'd15});
        req[2] = 1'b1;
        step();
        chk("h1_req_edge1", o0_req, 0);
        chk("h1_fields", out_pkt(), {4'd3, 4'd1, 8'd5, 4'd15});
        chk("h1_busy", dbg_busy, 1);
        step();
        chk("h1_req_edge2", o0_req, 1);
        o0_ack = 1'b1;
        step();
        chk("h1_req_drop", o0_req, 0);
        chk("h1_ack_early", ack[2], 0);
        step();
        chk("h1_ack_held", ack[2], 0);
        o0_ack = 1'b0;
        step();
        chk("h1_ack_rise", ack, 4'b0100);
        req[2] = 1'b0;
        step();
        chk("h1_ack_fall", ack, 0);
        chk("h1_cnt", dbg_pkt_cnt, 1);
        chk("h1_grant", dbg_grant, 2);
        chk("h1_idle", dbg_busy, 0);

        // ---------------- reset mid-transfer with i3 in IN_ACK ----------------
        set_src(3, {4'd7, 4'd2, 8'hA5, 4'd9});
        req[3] = 1'b1;
        step(); step();
        chk("h4_req", o0_req, 1);
        o0_ack = 1'b1;
        step();
        o0_ack = 1'b0;
        step();
        chk("h4_ack3", ack, 4'b1000);
        #2 rst = 1'b1;
        #1;
        chk("h4_async_ack", ack, 0);
        chk("h4_async_req", o0_req, 0);
        chk("h4_async_cnt", dbg_pkt_cnt, 0);
        chk("h4_async_busy", dbg_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        prev_req = 0;
        step();
        chk("h4_regrant", dbg_grant, 3);
        chk("h4_regrant_busy", dbg_busy, 1);
        step();
        chk("h4_req2", o0_req, 1);
        o0_ack = 1'b1;
        step();
        o0_ack = 1'b0;
        step();
        chk("h4_ack3b", ack, 4'b1000);
        req[3] = 1'b0;
        step();
        chk("h4_cnt", dbg_pkt_cnt, 1);

        // ---------------- slow sink on i0 ----------------
        do_reset();
        set_src(0, {4'd1, 4'd14, 8'h3C, 4'd6});
        req[0] = 1'b1;
        step(); step();
        chk("h2_req", o0_req, 1);
        for (int c = 0; c < 7; c++) begin
            step();
            chk("h2_req_hold", o0_req, 1);
            chk("h2_no_ack", ack[0], 0);
        end
        o0_ack = 1'b1;
        step();
        chk("h2_req_drop", o0_req, 0);
        for (int c = 0; c < 7; c++) begin
            step();
            chk("h2_ack_wait", ack[0], 0);
        end
        o0_ack = 1'b0;
        step();
        chk("h2_ack_rise", ack, 4'b0001);
        req[0] = 1'b0;
        step();
        chk("h2_ack_fall", ack, 0);

        // ---------------- sink ack stuck high across reset, i1 requesting ----------------
        agents_on = 0;
        rst = 1'b1; o0_ack = 1'b1;
        set_src(1, {4'd5, 4'd6, 8'h77, 4'd3});
        req = 4'b0010;
        @(negedge clk);
        rst = 1'b0;
        prev_req = 0;
        step();
        chk("h3_grant", dbg_grant, 1);
        chk("h3_busy", dbg_busy, 1);
        chk("h3_no_req", o0_req, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("h3_hold", o0_req, 0);
        end
        o0_ack = 1'b0;
        step();
        chk("h3_req_rise", o0_req, 1);
        o0_ack = 1'b1;
        step();
        o0_ack = 1'b0;
        step();
        chk("h3_ack", ack, 4'b0010);
        req[1] = 1'b0;
        step();
        chk("h3_cnt", dbg_pkt_cnt, 1);

        // ---------------- counter wrap: 256 transfers from i1 ----------------
        do_reset();
        for (int n = 0; n < 256; n++) srcq[1].push_back({4'd1, 4'(n), 8'(n), 4'(n >> 4)});
        drain();
        chk("wrap_model", mcnt, 256);
        chk("wrap_cnt", dbg_pkt_cnt, 0);
        chk("wrap_grant", dbg_grant, 1);

        // ---------------- randomized traffic with random handshake delays ----------------
        do_reset();
        rmax = 3;
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 4; k++) begin
                int m;
                m = int'($urandom_range(3, 0));
                for (int p = 0; p < m; p++) srcq[k].push_back(pkt_t'($urandom()));
            end
            drain();
            chk("rnd_cnt", dbg_pkt_cnt, 32'(mcnt % 256));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
